// File: rtl/half_adder_core_if.sv
// Bus bundle for half_adder_core: operand/valid inputs plus combinational,
// registered and statistics outputs. Parameters must match the attached core.
interface half_adder_core_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Sum;
  logic [WIDTH-1:0] Carry;
  logic             out_valid;
  logic [WIDTH-1:0] Sum_q;
  logic [WIDTH-1:0] Carry_q;
  logic [CNT_W-1:0] carry_count;

  modport master (
    output in_valid, A, B,
    input  Sum, Carry, out_valid, Sum_q, Carry_q, carry_count
  );

  modport slave (
    input  in_valid, A, B,
    output Sum, Carry, out_valid, Sum_q, Carry_q, carry_count
  );
endinterface

// File: rtl/half_adder_core.sv
// Lane-wise half adder with a zero-latency path and a 1-cycle valid-qualified copy.
// Optional saturating carry-event counter is built only when HALF_ADDER_STATS_EN is defined.
module half_adder_core #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  half_adder_core_if.slave bus
);
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] carry_c;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] carry_r;
  logic             valid_r;

  assign sum_c     = bus.A ^ bus.B;
  assign carry_c   = bus.A & bus.B;
  assign bus.Sum   = sum_c;
  assign bus.Carry = carry_c;

  // Data registers hold across idle beats so downstream can re-read the last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      sum_r   <= '0;
      carry_r <= '0;
    end else begin
      valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        sum_r   <= sum_c;
        carry_r <= carry_c;
      end
    end
  end

  assign bus.out_valid = valid_r;
  assign bus.Sum_q     = sum_r;
  assign bus.Carry_q   = carry_r;

`ifdef HALF_ADDER_STATS_EN
  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next;

  // One extra bit of headroom lets the overflow compare see past all-ones.
  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + PC_W'(carry_c[i]);
    end
    acc = SUM_W'(cnt_r) + SUM_W'(pc);
    if (acc > SUM_W'({CNT_W{1'b1}})) begin
      cnt_next = '1;
    end else begin
      cnt_next = acc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (bus.in_valid) begin
      cnt_r <= cnt_next;
    end
  end

  assign bus.carry_count = cnt_r;
`else
  assign bus.carry_count = '0;
`endif
endmodule

// File: tb/tb_half_adder_core.sv
// Directed bench for half_adder_core: WIDTH=1 and WIDTH=4/CNT_W=3 instances share clk/rst.
module tb_half_adder_core;
`ifdef HALF_ADDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  half_adder_core_if #(.WIDTH(1), .CNT_W(16)) if1 ();
  half_adder_core_if #(.WIDTH(4), .CNT_W(3))  if4 ();

  half_adder_core #(.WIDTH(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  half_adder_core #(.WIDTH(4), .CNT_W(3))  dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic [3:0] carry;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000};
    vecs[2] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    vecs[3] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001};
    vecs[4] = '{4'b1100, 4'b1010, 4'b0110, 4'b1000};
    vecs[5] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111};
    vecs[6] = '{4'b0101, 4'b1010, 4'b1111, 4'b0000};
    vecs[7] = '{4'b1001, 4'b0011, 4'b1010, 4'b0001};

    if1.in_valid = 1'b0; if1.A = '0; if1.B = '0;
    if4.in_valid = 1'b0; if4.A = '0; if4.B = '0;

    // Reset state, both before and after a clock edge under reset
    #3;
    check("rst_out_valid_pre", 64'(if1.out_valid), 64'd0);
    check("rst_carry_q_pre", 64'(if4.Carry_q), 64'd0);
    tick();
    check("rst_out_valid1", 64'(if1.out_valid), 64'd0);
    check("rst_sum_q1", 64'(if1.Sum_q), 64'd0);
    check("rst_carry_q1", 64'(if1.Carry_q), 64'd0);
    check("rst_count1", 64'(if1.carry_count), 64'd0);
    check("rst_out_valid4", 64'(if4.out_valid), 64'd0);
    check("rst_count4", 64'(if4.carry_count), 64'd0);

    @(negedge clk);
    rst = 1'b0;

    // Combinational table; WIDTH=1 instance sees lane 0 only
    for (int i = 0; i < 8; i++) begin
      if1.A = vecs[i].a[0];
      if1.B = vecs[i].b[0];
      if4.A = vecs[i].a;
      if4.B = vecs[i].b;
      #1;
      check($sformatf("comb_sum4[%0d]", i), 64'(if4.Sum), 64'(vecs[i].sum));
      check($sformatf("comb_carry4[%0d]", i), 64'(if4.Carry), 64'(vecs[i].carry));
      check($sformatf("comb_sum1[%0d]", i), 64'(if1.Sum), 64'(vecs[i].sum[0]));
      check($sformatf("comb_carry1[%0d]", i), 64'(if1.Carry), 64'(vecs[i].carry[0]));
      #9;
    end
    check("comb_no_capture_valid4", 64'(if4.out_valid), 64'd0);
    check("comb_no_capture_sum_q4", 64'(if4.Sum_q), 64'd0);

    // Registered capture on WIDTH=1, then hold on an idle beat
    @(negedge clk);
    if1.in_valid = 1'b1; if1.A = 1'b1; if1.B = 1'b1;
    if4.in_valid = 1'b0;
    tick();
    check("reg_out_valid1", 64'(if1.out_valid), 64'd1);
    check("reg_sum_q1", 64'(if1.Sum_q), 64'd0);
    check("reg_carry_q1", 64'(if1.Carry_q), 64'd1);
    check("reg_count1", 64'(if1.carry_count), STATS ? 64'd1 : 64'd0);
    @(negedge clk);
    if1.in_valid = 1'b0; if1.A = 1'b0; if1.B = 1'b1;
    tick();
    check("hold_out_valid1", 64'(if1.out_valid), 64'd0);
    check("hold_sum_q1", 64'(if1.Sum_q), 64'd0);
    check("hold_carry_q1", 64'(if1.Carry_q), 64'd1);
    check("hold_count1", 64'(if1.carry_count), STATS ? 64'd1 : 64'd0);

    // Registered capture on WIDTH=4, lanes independent
    @(negedge clk);
    if4.in_valid = 1'b1; if4.A = 4'b1100; if4.B = 4'b1010;
    tick();
    check("reg_out_valid4", 64'(if4.out_valid), 64'd1);
    check("reg_sum_q4", 64'(if4.Sum_q), 64'h6);
    check("reg_carry_q4", 64'(if4.Carry_q), 64'h8);
    check("reg_count4", 64'(if4.carry_count), STATS ? 64'd1 : 64'd0);

    // Mid-stream async reset between edges
    @(negedge clk);
    if1.in_valid = 1'b1; if1.A = 1'b1; if1.B = 1'b1;
    if4.in_valid = 1'b0;
    tick();
    check("pre_rst_out_valid1", 64'(if1.out_valid), 64'd1);
    check("pre_rst_carry_q1", 64'(if1.Carry_q), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid1", 64'(if1.out_valid), 64'd0);
    check("async_rst_sum_q1", 64'(if1.Sum_q), 64'd0);
    check("async_rst_carry_q1", 64'(if1.Carry_q), 64'd0);
    check("async_rst_carry_q4", 64'(if4.Carry_q), 64'd0);
    check("async_rst_count4", 64'(if4.carry_count), 64'd0);
    check("async_rst_count1", 64'(if1.carry_count), 64'd0);
    check("async_rst_comb_sum1", 64'(if1.Sum), 64'd0);
    check("async_rst_comb_carry1", 64'(if1.Carry), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    if1.in_valid = 1'b0;
    tick();
    check("post_rst_no_capture1", 64'(if1.out_valid), 64'd0);
    check("post_rst_carry_q1", 64'(if1.Carry_q), 64'd0);

    // Saturating counter on CNT_W=3
    @(negedge clk);
    if4.in_valid = 1'b1; if4.A = 4'hF; if4.B = 4'hF;
    tick();
    check("count_beat1", 64'(if4.carry_count), STATS ? 64'd4 : 64'd0);
    check("count_beat1_carry_q", 64'(if4.Carry_q), 64'hF);
    tick();
    check("count_beat2_sat", 64'(if4.carry_count), STATS ? 64'd7 : 64'd0);
    tick();
    check("count_beat3_sat", 64'(if4.carry_count), STATS ? 64'd7 : 64'd0);
    @(negedge clk);
    if4.in_valid = 1'b0;
    tick();
    check("count_idle_hold", 64'(if4.carry_count), STATS ? 64'd7 : 64'd0);
    check("count_idle_valid", 64'(if4.out_valid), 64'd0);
    #1;
    rst = 1'b1;
    #1;
    check("count_rst_clear", 64'(if4.carry_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/half_adder_core.md
Name: half_adder_core

Overview:
- Parameterised, lane-wise half adder: each bit lane computes Sum = A XOR B and Carry = A AND B.
- Combinational outputs serve zero-latency use.
- A registered, valid-qualified copy serves pipelined datapaths.
- Used as the leaf bit-cell and as a small pipelined stage in adder trees.

Parameters:
- WIDTH, 1, number of independent half-adder lanes; legal range 1..64.
- CNT_W, 16, width of the carry-event counter; used only when HALF_ADDER_STATS_EN is defined.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies A/B for capture into the registered path.
- A  input  WIDTH  operand A, one bit per lane.
- B  input  WIDTH  operand B, one bit per lane.
- Sum  output  WIDTH  combinational A XOR B.
- Carry  output  WIDTH  combinational A AND B.
- out_valid  output  1  registered in_valid.
- Sum_q  output  WIDTH  registered Sum.
- Carry_q  output  WIDTH  registered Carry.
- carry_count  output  CNT_W  saturating carry-event count; all-zero when the feature is compiled out.

Behaviour:
- Combinational path: Sum[i] = A[i] ^ B[i]; Carry[i] = A[i] & B[i], for every lane i.
  - No dependence on clk, rst or in_valid.
  - Settles within the same delta cycle as the input change.
- Truth table per lane (A,B -> Sum,Carry): 00->00, 01->10, 10->10, 11->01.
- Lanes are fully independent; no carry propagates between lanes.
- Registered path: 1-cycle latency.
  - On rising clk with in_valid=1: Sum_q <= A^B, Carry_q <= A&B, out_valid <= 1.
  - On rising clk with in_valid=0: out_valid <= 0; Sum_q and Carry_q hold their previous values.
- Reset: while rst=1, out_valid, Sum_q, Carry_q and carry_count are all 0, regardless of clk.
  - Deassertion takes effect at the next rising clk edge; no capture occurs on that edge unless in_valid=1.
- Reset asserted mid-stream:
  - Registered outputs clear immediately (asynchronous).
  - Combinational Sum/Carry continue to track A/B.
- X on A/B propagates to Sum/Carry; no X-masking.
- No back-pressure; every valid beat is accepted.

Optional Feature:
- Macro: HALF_ADDER_STATS_EN.
- Defined:
  - carry_count increments on each rising clk where in_valid=1, by the popcount of (A & B) for that beat.
  - Saturates at all-ones; never wraps.
  - Cleared asynchronously by rst.
  - Updates in the same edge as Carry_q.
- Undefined:
  - Counter logic is absent; carry_count is driven constant 0.
  - Port list is unchanged.

Test Plan:
- WIDTH=1, rst=0: apply A,B = 00,01,10,11, each held 10 time units -> Sum,Carry = 00,10,10,01, checked immediately after each change.
- WIDTH=1, in_valid=1 with A=1,B=1 at edge n -> Sum_q=0, Carry_q=1, out_valid=1 after edge n. Next edge with in_valid=0 -> out_valid=0, Sum_q/Carry_q unchanged.
- WIDTH=4, A=4'b1100, B=4'b1010 -> Sum=4'b0110, Carry=4'b1000, with no inter-lane interaction.
- Assert rst asynchronously between edges while out_valid=1, Carry_q=1 -> out_valid, Sum_q, Carry_q go 0 before the next edge. Combinational Sum/Carry are unaffected.
- HALF_ADDER_STATS_EN, WIDTH=4, CNT_W=3: two valid beats of A=B=4'hF -> carry_count = 4, then 7 (saturated). A third beat keeps it at 7. rst returns it to 0.
- Without HALF_ADDER_STATS_EN: same stimulus -> carry_count stays 0.
